pow_n_collect: RTL and testbench
================================

POW_N_COLLECT -- requirements
Module: pow_n_collect

Interface
REQ-001 Parameter w, default 8: data width of each power term.
REQ-002 Parameter n, default 5: number of power terms per argument (arg^1..arg^n).
REQ-003 Parameter depth, default 4: FIFO entries, power of two, at least 2.
REQ-004 clk  input  1: single clock, all state on rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 in_vld  input  n: staggered valids from the upstream pow_n pipe; bit n-p marks term arg^p, which lags the argument by p cycles.
REQ-007 in_data  input  n*w: staggered terms; slice [(n-p)*w +: w] holds arg^p.
REQ-008 out_vld  output  1: serial output beat valid.
REQ-009 out_rdy  input  1: downstream accepts beat when out_vld && out_rdy.
REQ-010 out_data  output  w: current power term.
REQ-011 out_pow  output  $clog2(n+1): exponent of out_data, 1..n.
REQ-012 out_last  output  1: high on the arg^n beat.
REQ-013 overflow  output  1: sticky flag, a complete vector was dropped.
REQ-014 drop_cnt  output  8: dropped-vector count (see Configuration).

Function
REQ-015 Alignment: term p (p = 1..n-1) SHALL pass through (n-p) data-only registers (no reset); term n is taken directly, so all n terms of one argument are present together in the cycle in_vld[0]=1.
REQ-016 in_vld[0] SHALL be the sole push qualifier; in_vld[n-1:1] are ignored for control.
REQ-017 Push: when in_vld[0]=1 and the FIFO is not full, or the FIFO is full but pops in the same cycle, the aligned n*w vector SHALL be written.
REQ-018 Drop: when in_vld[0]=1, the FIFO is full and there is no same-cycle pop, the vector SHALL be discarded, overflow SHALL set, and drop_cnt SHALL increment.
REQ-019 FIFO pointers SHALL wrap modulo depth; full/empty SHALL be derived from a count of 0..depth.
REQ-020 Serializer FSM states: IDLE (no vector held) and EMIT (vector held, index k = 1..n).
REQ-021 IDLE -> EMIT: on FIFO non-empty, pop one entry into the shift register, k=1.
REQ-022 EMIT: out_vld=1, out_data=term k, out_pow=k, out_last=(k==n); on accept with k<n, k increments.
REQ-023 On accept with k==n: if the FIFO is non-empty, pop and restart at k=1 in the same edge (back-to-back, no bubble); otherwise go to IDLE.
REQ-024 out_data, out_pow and out_last SHALL hold stable while out_vld=1 and out_rdy=0.
REQ-025 Latency: with the FIFO empty and the FSM in IDLE, out_vld SHALL rise exactly 2 cycles after the in_vld[0] cycle.
REQ-026 Throughput: one beat per cycle with out_rdy held 1; the FIFO absorbs bursts of up to depth vectors plus the one held in the serializer.
REQ-027 Arithmetic: terms pass unmodified, already truncated to w bits upstream.

Reset
REQ-028 Reset asserted SHALL force: FIFO empty, FSM IDLE, out_vld=0, out_pow=0, out_last=0, out_data=0, overflow=0, drop_cnt=0.
REQ-029 Reset mid-operation SHALL discard all held, queued and in-flight vectors; no beat SHALL be emitted for them after release.
REQ-030 Alignment data registers SHALL not be reset.

Configuration
REQ-031 Macro POW_N_COLLECT_DROP_CNT_EN defined: drop_cnt SHALL be an 8-bit counter saturating at 255, cleared only by reset.
REQ-032 Macro undefined: drop_cnt SHALL be tied to 0, with no counter logic; overflow behaviour is unchanged.

Verification (w=8, n=5, depth=4)
REQ-033 Single arg=3 through upstream, out_rdy=1 -> beats 3,9,27,81,243 with out_pow 1..5, out_last on 243, out_vld rising 2 cycles after in_vld[0].
REQ-034 Args 2,5 back-to-back, out_rdy=1 -> 2,4,8,16,32 then 5,25,125,113,53, with no gap between vectors.
REQ-035 out_rdy=0 for 3 cycles during the third beat of arg=3 -> out_data holds 27 and out_pow holds 3; the stream resumes intact.
REQ-036 out_rdy=0, 6 consecutive args -> first 5 retained (1 in the serializer, 4 in the FIFO), sixth dropped; overflow=1; drop_cnt=1 with the macro, 0 without.
REQ-037 rst_n pulsed low mid-vector -> all outputs 0 immediately; no stale beats after release; the next arg=2 emits 2,4,8,16,32.

Source files
------------

// File: rtl/pow_n_collect.sv
// Aligns the staggered pow_n terms of one argument, queues them and emits them as a serial beat stream.
// Optional drop counter: define POW_N_COLLECT_DROP_CNT_EN.
module pow_n_collect #(
    parameter int unsigned w     = 8,
    parameter int unsigned n     = 5,
    parameter int unsigned depth = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [n-1:0]               in_vld,
    input  logic [n*w-1:0]             in_data,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [w-1:0]               out_data,
    output logic [$clog2(n+1)-1:0]     out_pow,
    output logic                       out_last,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int unsigned pw = $clog2(n + 1);
    localparam int unsigned aw = $clog2(depth);
    localparam int unsigned cw = $clog2(depth + 1);
    localparam int unsigned vw = n * w;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              pop;
    logic              load;
    logic              shift;
    logic              finish;
    logic              push;
    logic              drop;
    logic              full;
    logic              empty;
    logic [vw-1:0]     aligned;
    logic [vw-1:0]     mem [depth];
    logic [aw-1:0]     wr_ptr;
    logic [aw-1:0]     rd_ptr;
    logic [cw-1:0]     count;
    logic [vw-1:0]     shreg;
    logic              unused_vld;

    // Only in_vld[0] qualifies a push; the other valids are informational.
    assign unused_vld = ^in_vld[n-1:1];

    // Aligned vector is repacked so term p sits at [(p-1)*w], letting the serializer shift right.
    assign aligned[(n-1)*w +: w] = in_data[0 +: w];

    for (genvar p = 1; p < n; p++) begin : g_align
        logic [w-1:0] dly [n-p];

        always_ff @(posedge clk) begin
            dly[0] <= in_data[(n-p)*w +: w];
            for (int i = 1; i < int'(n - p); i++) begin
                dly[i] <= dly[i-1];
            end
        end

        assign aligned[(p-1)*w +: w] = dly[n-p-1];
    end

    assign full  = (count == cw'(depth));
    assign empty = (count == '0);
    assign push  = in_vld[0] && (!full || pop);
    assign drop  = in_vld[0] && full && !pop;

    // FIFO storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= aligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            count <= count + cw'(push) - cw'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Serializer control: a pop on the last accepted beat restarts without a bubble.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (out_rdy) begin
                    if (!out_last) begin
                        shift = 1'b1;
                    end else if (!empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            out_vld  <= 1'b0;
            out_pow  <= '0;
            out_last <= 1'b0;
        end else if (load) begin
            shreg    <= mem[rd_ptr];
            out_vld  <= 1'b1;
            out_pow  <= pw'(1);
            out_last <= (n == 1);
        end else if (shift) begin
            shreg    <= shreg >> w;
            out_pow  <= out_pow + pw'(1);
            out_last <= (out_pow == pw'(n - 1));
        end else if (finish) begin
            shreg    <= '0;
            out_vld  <= 1'b0;
            out_pow  <= '0;
            out_last <= 1'b0;
        end
    end

    assign out_data = shreg[w-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef POW_N_COLLECT_DROP_CNT_EN
    logic [7:0] drop_q;

    // Saturating count of discarded vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pow_n_collect.sv
// Self-checking bench for pow_n_collect: an upstream pow_n model drives staggered terms,
// a monitor records accepted beats and a power-of-argument model supplies expectations.
module tb_pow_n_collect;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 5;
    localparam int unsigned D  = 4;
    localparam int unsigned PW = $clog2(N + 1);
    localparam int unsigned DW = N * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  in_vld;
    logic [DW-1:0] in_data;
    logic          out_vld;
    logic          out_rdy = 1'b1;
    logic [W-1:0]  out_data;
    logic [PW-1:0] out_pow;
    logic          out_last;
    logic          overflow;
    logic [7:0]    drop_cnt;

    int cyc = 0;
    int sched_a[$];
    int sched_c[$];
    logic [W-1:0]  got_d[$];
    logic [PW-1:0] got_p[$];
    logic          got_l[$];
    int            got_c[$];
    int done_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;

    pow_n_collect #(.w(W), .n(N), .depth(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_pow(out_pow), .out_last(out_last), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // arg^p truncated to W bits, as the upstream pipe delivers it
    function automatic logic [W-1:0] pw_of(input int a, input int p);
        int r;
        r = 1;
        for (int i = 0; i < p; i++) r = (r * a) % (1 << W);
        return W'(r);
    endfunction

    // Upstream model: term p of an argument issued in cycle c appears on bit N-p in cycle c+p.
    initial begin
        logic [N-1:0]  v;
        logic [DW-1:0] d;
        in_vld  = '0;
        in_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            v = '0;
            d = DW'({$urandom(), $urandom()});
            for (int j = 0; j < sched_a.size(); j++) begin
                int k;
                k = cyc - sched_c[j];
                if (k >= 1 && k <= int'(N)) begin
                    v[N-k] = 1'b1;
                    d[(N-k)*W +: W] = pw_of(sched_a[j], k);
                end
            end
            while (sched_c.size() > 0 && cyc - sched_c[0] >= int'(N)) begin
                void'(sched_a.pop_front());
                void'(sched_c.pop_front());
            end
            in_vld  = v;
            in_data = d;
        end
    end

    // Monitor: records accepted beats and checks outputs hold while stalled.
    initial begin
        logic          stall;
        logic [W-1:0]  pd;
        logic [PW-1:0] pp;
        logic          pl;
        stall = 1'b0;
        pd = '0; pp = '0; pl = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    n_checks++;
                    if (out_vld !== 1'b1 || out_data !== pd || out_pow !== pp || out_last !== pl) begin
                        n_fail++;
                        $display("FAIL hold_stable cyc=%0d got vld=%0b data=%0d pow=%0d last=%0b exp vld=1 data=%0d pow=%0d last=%0b",
                                 cyc, out_vld, out_data, out_pow, out_last, pd, pp, pl);
                    end
                end
                if (out_vld && out_rdy) begin
                    got_d.push_back(out_data);
                    got_p.push_back(out_pow);
                    got_l.push_back(out_last);
                    got_c.push_back(cyc);
                    if (out_last) done_cnt++;
                end
                stall = out_vld && !out_rdy;
                pd = out_data; pp = out_pow; pl = out_last;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic cycles(input int k);
        repeat (k) step();
    endtask

    task automatic issue(input int a);
        sched_a.push_back(a);
        sched_c.push_back(cyc);
    endtask

    task automatic clear_got();
        got_d.delete(); got_p.delete(); got_l.delete(); got_c.delete();
    endtask

    task automatic wait_beats(input int cnt, input int budget);
        int b;
        b = 0;
        while (got_d.size() < cnt && b < budget) begin
            step();
            b++;
        end
    endtask

    task automatic test_reset();
        cycles(2);
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %0b exp 0", out_vld); end
        n_checks++; if (out_pow !== '0) begin n_fail++; $display("FAIL reset_pow got %0d exp 0", out_pow); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %0b exp 0", out_last); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %0d exp 0", out_data); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_single();
        int t0;
        clear_got();
        t0 = cyc;
        issue(3);
        wait_beats(5, 40);
        cycles(3);
        n_checks++; if (got_d.size() !== 5) begin n_fail++; $display("FAIL single_count got %0d exp 5", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 5; i++) begin
            n_checks++;
            if (got_d[i] !== pw_of(3, i + 1) || got_p[i] !== PW'(i + 1) || got_l[i] !== (i == 4)) begin
                n_fail++;
                $display("FAIL single_beat%0d got data=%0d pow=%0d last=%0b exp data=%0d pow=%0d last=%0b",
                         i, got_d[i], got_p[i], got_l[i], pw_of(3, i + 1), i + 1, i == 4);
            end
        end
        if (got_c.size() > 0) begin
            n_checks++;
            if (got_c[0] !== t0 + int'(N) + 2) begin
                n_fail++;
                $display("FAIL single_latency got cyc %0d exp cyc %0d", got_c[0], t0 + int'(N) + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int args[2];
        args[0] = 2; args[1] = 5;
        clear_got();
        issue(args[0]);
        step();
        issue(args[1]);
        wait_beats(10, 60);
        cycles(3);
        n_checks++; if (got_d.size() !== 10) begin n_fail++; $display("FAIL b2b_count got %0d exp 10", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 10; i++) begin
            n_checks++;
            if (got_d[i] !== pw_of(args[i/N], i%N + 1) || got_p[i] !== PW'(i%N + 1) || got_l[i] !== (i%N == N-1)) begin
                n_fail++;
                $display("FAIL b2b_beat%0d got data=%0d pow=%0d last=%0b exp data=%0d pow=%0d",
                         i, got_d[i], got_p[i], got_l[i], pw_of(args[i/N], i%N + 1), i%N + 1);
            end
        end
        if (got_c.size() >= 10) begin
            n_checks++;
            if (got_c[9] - got_c[0] !== 9) begin
                n_fail++;
                $display("FAIL b2b_gap got span %0d exp 9", got_c[9] - got_c[0]);
            end
        end
    endtask

    task automatic test_stall();
        int b;
        clear_got();
        issue(3);
        b = 0;
        while (!(out_vld === 1'b1 && out_pow === PW'(3)) && b < 40) begin
            step();
            b++;
        end
        out_rdy = 1'b0;
        n_checks++; if (b >= 40) begin n_fail++; $display("FAIL stall_reach got timeout exp pow 3 beat"); end
        repeat (3) begin
            step();
            n_checks++;
            if (out_data !== 8'd27 || out_pow !== PW'(3)) begin
                n_fail++;
                $display("FAIL stall_hold got data=%0d pow=%0d exp data=27 pow=3", out_data, out_pow);
            end
        end
        out_rdy = 1'b1;
        wait_beats(5, 40);
        cycles(3);
        n_checks++; if (got_d.size() !== 5) begin n_fail++; $display("FAIL stall_count got %0d exp 5", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 5; i++) begin
            n_checks++;
            if (got_d[i] !== pw_of(3, i + 1) || got_p[i] !== PW'(i + 1) || got_l[i] !== (i == 4)) begin
                n_fail++;
                $display("FAIL stall_beat%0d got data=%0d pow=%0d exp data=%0d pow=%0d",
                         i, got_d[i], got_p[i], pw_of(3, i + 1), i + 1);
            end
        end
    endtask

    task automatic test_random();
        int args[$];
        int issued;
        int base;
        int b;
        clear_got();
        issued = 0;
        base = done_cnt;
        b = 0;
        while ((issued < 20 || done_cnt - base < 20) && b < 3000) begin
            step();
            b++;
            out_rdy = ($urandom_range(3) != 0);
            if (issued < 20 && issued - (done_cnt - base) < 3 && $urandom_range(2) == 0) begin
                int a;
                a = int'($urandom_range(255));
                args.push_back(a);
                issue(a);
                issued++;
            end
        end
        out_rdy = 1'b1;
        cycles(3);
        n_checks++; if (got_d.size() !== 100) begin n_fail++; $display("FAIL random_count got %0d exp 100", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 100; i++) begin
            n_checks++;
            if (got_d[i] !== pw_of(args[i/N], i%N + 1) || got_p[i] !== PW'(i%N + 1) || got_l[i] !== (i%N == N-1)) begin
                n_fail++;
                $display("FAIL random_beat%0d got data=%0d pow=%0d last=%0b exp data=%0d pow=%0d",
                         i, got_d[i], got_p[i], got_l[i], pw_of(args[i/N], i%N + 1), i%N + 1);
            end
        end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL random_overflow got %0b exp 0", overflow); end
    endtask

    task automatic test_overflow();
        int args[6];
        logic [7:0] exp_drop;
`ifdef POW_N_COLLECT_DROP_CNT_EN
        exp_drop = 8'd1;
`else
        exp_drop = 8'd0;
`endif
        clear_got();
        out_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            args[i] = int'($urandom_range(1, 255));
            issue(args[i]);
            step();
        end
        cycles(N + 4);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
        n_checks++; if (drop_cnt !== exp_drop) begin n_fail++; $display("FAIL ovf_drop_cnt got %0d exp %0d", drop_cnt, exp_drop); end
        n_checks++; if (got_d.size() !== 0) begin n_fail++; $display("FAIL ovf_no_accept got %0d exp 0", got_d.size()); end
        out_rdy = 1'b1;
        wait_beats(25, 80);
        cycles(8);
        n_checks++; if (got_d.size() !== 25) begin n_fail++; $display("FAIL ovf_count got %0d exp 25", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 25; i++) begin
            n_checks++;
            if (got_d[i] !== pw_of(args[i/N], i%N + 1) || got_p[i] !== PW'(i%N + 1) || got_l[i] !== (i%N == N-1)) begin
                n_fail++;
                $display("FAIL ovf_beat%0d got data=%0d pow=%0d exp data=%0d pow=%0d",
                         i, got_d[i], got_p[i], pw_of(args[i/N], i%N + 1), i%N + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_got();
        issue(7);
        wait_beats(2, 40);
        issue(9);
        step();
        step();
        #2;
        rst_n = 1'b0;
        sched_a.delete();
        sched_c.delete();
        #1;
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_vld got %0b exp 0", out_vld); end
        n_checks++; if (out_data !== '0 || out_pow !== '0 || out_last !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outs got data=%0d pow=%0d last=%0b exp 0", out_data, out_pow, out_last);
        end
        n_checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL midrst_ovf got ovf=%0b drop=%0d exp 0", overflow, drop_cnt);
        end
        cycles(3);
        rst_n = 1'b1;
        clear_got();
        cycles(15);
        n_checks++; if (got_d.size() !== 0) begin n_fail++; $display("FAIL midrst_stale got %0d beats exp 0", got_d.size()); end
        issue(2);
        wait_beats(5, 40);
        cycles(3);
        n_checks++; if (got_d.size() !== 5) begin n_fail++; $display("FAIL midrst_count got %0d exp 5", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 5; i++) begin
            n_checks++;
            if (got_d[i] !== pw_of(2, i + 1) || got_p[i] !== PW'(i + 1) || got_l[i] !== (i == 4)) begin
                n_fail++;
                $display("FAIL midrst_beat%0d got data=%0d pow=%0d exp data=%0d pow=%0d",
                         i, got_d[i], got_p[i], pw_of(2, i + 1), i + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
